// File: rtl/alu_seq_param_if.sv
// Request/response bus of the sequential ALU: a valid/ready request channel
// carrying opcode and operands, and a valid/ready result channel carrying
// result, full product and status flags.
interface alu_seq_param_if #(
  parameter int WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           opcode;
  logic [WIDTH-1:0]     operand1;
  logic [WIDTH-1:0]     operand2;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     result;
  logic [2*WIDTH-1:0]   product;
  logic                 carry_out;
  logic                 overflow;
  logic                 zero;

  // Requester side: issues operations and consumes results.
  modport master (
    output in_valid, opcode, operand1, operand2, out_ready,
    input  in_ready, out_valid, result, product, carry_out, overflow, zero
  );

  // ALU side.
  modport slave (
    input  in_valid, opcode, operand1, operand2, out_ready,
    output in_ready, out_valid, result, product, carry_out, overflow, zero
  );
endinterface

// File: rtl/alu_seq_param.sv
// Sequential ALU. Single-cycle operations complete one cycle after accept;
// MUL runs an iterative shift-add multiplier, one multiplier bit per cycle,
// and completes WIDTH+1 cycles after accept. Results are held until the
// consumer takes them.
module alu_seq_param #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_seq_param_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_HOLD
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_INCR = 4'd3,
    OP_DECR = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_NOT  = 4'd7,
    OP_NAND = 4'd8,
    OP_NOR  = 4'd9,
    OP_XOR  = 4'd10,
    OP_XNOR = 4'd11,
    OP_ARSH = 4'd12,
    OP_ALSH = 4'd13,
    OP_LRSH = 4'd14,
    OP_LLSH = 4'd15
  } opcode_e;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             ovf;
  } alu_res_t;

  // Single-cycle operations; MUL is handled by the iterative datapath.
  function automatic alu_res_t alu_eval(input opcode_e op,
                                        input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b);
    alu_res_t         r;
    logic [WIDTH:0]   wide;
    logic [SHW-1:0]   s;
    r    = '0;
    wide = '0;
    s    = b[SHW-1:0];
    case (op)
      OP_ADD: begin
        wide     = {1'b0, a} + {1'b0, b};
        r.result = wide[WIDTH-1:0];
        r.carry  = wide[WIDTH];
        r.ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (wide[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // Bit WIDTH of the extended difference is the borrow.
        wide     = {1'b0, a} - {1'b0, b};
        r.result = wide[WIDTH-1:0];
        r.carry  = wide[WIDTH];
        r.ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (wide[WIDTH-1] != a[WIDTH-1]);
      end
      OP_INCR: begin
        r.result = a + WIDTH'(1);
        r.carry  = &a;
        r.ovf    = ~a[WIDTH-1] & r.result[WIDTH-1];
      end
      OP_DECR: begin
        r.result = a - WIDTH'(1);
        r.carry  = ~|a;
        r.ovf    = a[WIDTH-1] & ~r.result[WIDTH-1];
      end
      OP_AND:  r.result = a & b;
      OP_OR:   r.result = a | b;
      OP_NOT:  r.result = ~a;
      OP_NAND: r.result = ~(a & b);
      OP_NOR:  r.result = ~(a | b);
      OP_XOR:  r.result = a ^ b;
      OP_XNOR: r.result = ~(a ^ b);
      OP_ARSH: r.result = $unsigned($signed(a) >>> s);
      OP_LRSH: r.result = a >> s;
      OP_ALSH, OP_LLSH: r.result = a << s;
      default: r = '0;
    endcase
    return r;
  endfunction

  state_e               state_q, state_d;
  logic [SHW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 carry_q, carry_d;
  logic                 ovf_q, ovf_d;
  logic                 zero_q, zero_d;

  alu_res_t             alu_r;
  logic [2*WIDTH-1:0]   partial;

  // Next-state, capture, multiplier step and output register computation.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    product_d   = product_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;

    alu_r   = alu_eval(opcode_e'(bus.opcode), bus.operand1, bus.operand2);
    // Add the multiplicand, weighted by the current bit position, when the
    // current multiplier bit is set.
    partial = acc_q + (b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0);

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d = bus.operand1;
          b_d = bus.operand2;
          if (opcode_e'(bus.opcode) == OP_MUL) begin
            state_d = S_BUSY;
            cnt_d   = '0;
            acc_d   = '0;
          end else begin
            state_d     = S_HOLD;
            out_valid_d = 1'b1;
            result_d    = alu_r.result;
            product_d   = '0;
            carry_d     = alu_r.carry;
            ovf_d       = alu_r.ovf;
            zero_d      = ~|alu_r.result;
          end
        end
      end
      S_BUSY: begin
        acc_d = partial;
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d     = S_HOLD;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          product_d   = partial;
          result_d    = partial[WIDTH-1:0];
          carry_d     = 1'b0;
          ovf_d       = |partial[2*WIDTH-1:WIDTH];
          zero_d      = ~|partial[WIDTH-1:0];
        end else begin
          cnt_d = cnt_q + SHW'(1);
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge
    // values computed above, independent of statement order.
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      product_q   <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      product_q   <= product_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.product   = product_q;
  assign bus.carry_out = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_alu_seq_param.sv
// Self-checking bench for alu_seq_param: directed corner cases, randomized
// operations against a behavioural model, a narrow-width multiplier
// instance, and reset abort during a multiply.
module tb_alu_seq_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_param_if #(.WIDTH(32)) bus32();
  alu_seq_param_if #(.WIDTH(8))  bus8();

  alu_seq_param #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  alu_seq_param #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] r;
    logic [63:0] p;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference: exact integer arithmetic, then wrap to 32 bits.
  // Signed overflow is present when the exact signed answer differs from
  // the wrapped answer read back as signed.
  function automatic exp_t model32(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    exp_t        e;
    longint      sa;
    longint      sb;
    longint      exact;
    logic [32:0] sum;
    logic [4:0]  s;
    e     = '0;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    s     = b[4:0];
    exact = 0;
    case (op)
      4'd0: begin
        sum   = {1'b0, a} + {1'b0, b};
        e.r   = sum[31:0];
        e.c   = sum[32];
        exact = sa + sb;
        e.v   = (exact != longint'($signed(e.r)));
      end
      4'd1: begin
        e.r   = a - b;
        e.c   = (a < b);
        exact = sa - sb;
        e.v   = (exact != longint'($signed(e.r)));
      end
      4'd2: begin
        e.p = {32'd0, a} * {32'd0, b};
        e.r = e.p[31:0];
        e.v = (e.p[63:32] != 32'd0);
      end
      4'd3: begin
        e.r   = a + 32'd1;
        e.c   = (a == 32'hFFFF_FFFF);
        exact = sa + 1;
        e.v   = (exact != longint'($signed(e.r)));
      end
      4'd4: begin
        e.r   = a - 32'd1;
        e.c   = (a == 32'd0);
        exact = sa - 1;
        e.v   = (exact != longint'($signed(e.r)));
      end
      4'd5:  e.r = a & b;
      4'd6:  e.r = a | b;
      4'd7:  e.r = ~a;
      4'd8:  e.r = ~(a & b);
      4'd9:  e.r = ~(a | b);
      4'd10: e.r = a ^ b;
      4'd11: e.r = ~(a ^ b);
      4'd12: begin
        exact = sa >>> s;
        e.r   = exact[31:0];
      end
      4'd14: e.r = a >> s;
      default: e.r = a << s;
    endcase
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  // Issue one operation on the 32-bit instance, check latency and outputs,
  // hold out_ready low for `stall` cycles while offering ignored requests,
  // then release the result.
  task automatic run32(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int stall);
    exp_t e;
    int   lat;
    int   exp_lat;
    e       = model32(op, a, b);
    exp_lat = (op == 4'd2) ? 33 : 1;
    @(negedge clk);
    check("in_ready_idle", 64'(bus32.in_ready), 64'(1));
    bus32.in_valid  = 1'b1;
    bus32.opcode    = op;
    bus32.operand1  = a;
    bus32.operand2  = b;
    bus32.out_ready = 1'b0;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    bus32.opcode   = 4'($urandom);
    bus32.operand1 = $urandom;
    bus32.operand2 = $urandom;
    lat = 1;
    while (!bus32.out_valid && lat < 40) begin
      check("in_ready_busy", 64'(bus32.in_ready), 64'(0));
      bus32.out_ready = 1'($urandom);
      bus32.in_valid  = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    bus32.out_ready = 1'b0;
    bus32.in_valid  = 1'b0;
    check($sformatf("latency op%0d", op), 64'(lat), 64'(exp_lat));
    check($sformatf("result op%0d a=%h b=%h", op, a, b), 64'(bus32.result), 64'(e.r));
    check($sformatf("product op%0d", op), bus32.product, e.p);
    check($sformatf("carry op%0d a=%h b=%h", op, a, b), 64'(bus32.carry_out), 64'(e.c));
    check($sformatf("overflow op%0d a=%h b=%h", op, a, b), 64'(bus32.overflow), 64'(e.v));
    check($sformatf("zero op%0d", op), 64'(bus32.zero), 64'(e.z));
    check("in_ready_hold", 64'(bus32.in_ready), 64'(0));
    for (int i = 0; i < stall; i++) begin
      bus32.in_valid = 1'b1;
      bus32.opcode   = 4'd0;
      bus32.operand1 = $urandom;
      bus32.operand2 = $urandom;
      @(posedge clk); #1;
      check("stall_valid", 64'(bus32.out_valid), 64'(1));
      check("stall_result", 64'(bus32.result), 64'(e.r));
      check("stall_product", bus32.product, e.p);
      check("stall_flags", 64'({bus32.carry_out, bus32.overflow, bus32.zero}),
            64'({e.c, e.v, e.z}));
      check("stall_in_ready", 64'(bus32.in_ready), 64'(0));
    end
    bus32.in_valid  = 1'b0;
    bus32.out_ready = 1'b1;
    @(posedge clk); #1;
    bus32.out_ready = 1'b0;
    check("release_valid", 64'(bus32.out_valid), 64'(0));
    check("release_in_ready", 64'(bus32.in_ready), 64'(1));
  endtask

  // Multiply on the 8-bit instance: latency WIDTH+1 = 9, in_ready low throughout.
  task automatic run8(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    int          lat;
    p = {8'd0, a} * {8'd0, b};
    @(negedge clk);
    check("w8_in_ready_idle", 64'(bus8.in_ready), 64'(1));
    bus8.in_valid = 1'b1;
    bus8.opcode   = 4'd2;
    bus8.operand1 = a;
    bus8.operand2 = b;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    bus8.operand1 = 8'($urandom);
    bus8.operand2 = 8'($urandom);
    lat = 1;
    while (!bus8.out_valid && lat < 20) begin
      check("w8_in_ready_busy", 64'(bus8.in_ready), 64'(0));
      @(posedge clk); #1;
      lat++;
    end
    check("w8_latency", 64'(lat), 64'(9));
    check($sformatf("w8_product %h*%h", a, b), 64'(bus8.product), 64'(p));
    check("w8_result", 64'(bus8.result), 64'(p[7:0]));
    check("w8_overflow", 64'(bus8.overflow), 64'(p[15:8] != 8'd0));
    check("w8_carry", 64'(bus8.carry_out), 64'(0));
    check("w8_zero", 64'(bus8.zero), 64'(p[7:0] == 8'd0));
    check("w8_in_ready_hold", 64'(bus8.in_ready), 64'(0));
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    check("w8_release", 64'(bus8.out_valid), 64'(0));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, 64'(bus32.out_valid), 64'(0));
    check({tag, "_result"}, 64'(bus32.result), 64'(0));
    check({tag, "_product"}, bus32.product, 64'(0));
    check({tag, "_flags"}, 64'({bus32.carry_out, bus32.overflow, bus32.zero}), 64'(0));
    check({tag, "_in_ready"}, 64'(bus32.in_ready), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          stale;

    bus32.in_valid = 1'b0; bus32.opcode = 4'd0; bus32.operand1 = '0;
    bus32.operand2 = '0;   bus32.out_ready = 1'b0;
    bus8.in_valid  = 1'b0; bus8.opcode  = 4'd0; bus8.operand1  = '0;
    bus8.operand2  = '0;   bus8.out_ready  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    check("reset_w8_valid", 64'(bus8.out_valid), 64'(0));
    check("reset_w8_product", 64'(bus8.product), 64'(0));
    check("reset_w8_in_ready", 64'(bus8.in_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases.
    run32(4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 0);
    run32(4'd1,  32'h8000_0000, 32'h0000_0001, 0);
    run32(4'd1,  32'h0000_0003, 32'h0000_0005, 0);
    run32(4'd12, 32'h8000_0000, 32'h0000_0004, 0);
    run32(4'd14, 32'h8000_0000, 32'h0000_0004, 0);
    run32(4'd15, 32'h0000_0001, 32'h0000_001F, 0);
    run32(4'd13, 32'h0000_0001, 32'h0000_001F, 0);
    run32(4'd12, 32'h8000_1234, 32'h0000_0020, 0);
    run32(4'd3,  32'h7FFF_FFFF, 32'h1234_5678, 0);
    run32(4'd4,  32'h0000_0000, 32'h1234_5678, 0);
    run32(4'd7,  32'hFFFF_FFFF, 32'h0000_0000, 0);
    run32(4'd5,  32'hF0F0_1234, 32'h0FF0_FFFF, 5);
    run32(4'd2,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    run32(4'd2,  32'h0000_0000, 32'h1234_5678, 0);

    // Randomized operations with occasional corner operands.
    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0:       a = 32'd0;
        1:       a = 32'hFFFF_FFFF;
        2:       a = 32'h8000_0000;
        3:       a = 32'h7FFF_FFFF;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      run32(op, a, b, $urandom_range(0, 2));
    end

    // Narrow instance multiplier.
    run8(8'hFF, 8'hFF);
    for (int i = 0; i < 6; i++) run8(8'($urandom), 8'($urandom));

    // Reset during the third BUSY cycle of a multiply aborts it.
    @(negedge clk);
    bus32.in_valid = 1'b1;
    bus32.opcode   = 4'd2;
    bus32.operand1 = 32'h1234_5678;
    bus32.operand2 = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_state("abort");
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus32.out_valid) stale++;
    end
    check("abort_no_valid", 64'(stale), 64'(0));
    run32(4'd0, 32'd2, 32'd2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
